serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port i_clk  input  1  rising-edge clock.
REQ-004 SHALL have port i_reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port i_valid  input  1  operands present on i_a/i_b.
REQ-006 SHALL have port o_ready  output  1  block can accept operands.
REQ-007 SHALL have port i_a  input  WIDTH  minuend.
REQ-008 SHALL have port i_b  input  WIDTH  subtrahend.
REQ-009 SHALL have port o_valid  output  1  result present on the outputs.
REQ-010 SHALL have port i_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port o_diff  output  WIDTH  i_a - i_b, modulo 2^WIDTH.
REQ-012 SHALL have port o_borrow  output  1  unsigned borrow out (i_a < i_b).

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 SHALL assert o_ready only in IDLE, and SHALL NOT assert it in any other state.
REQ-015 SHALL, in IDLE with i_valid=1, capture i_a and i_b into shift registers, clear the borrow flop and the bit counter, and move to RUN.
REQ-016 SHALL, in RUN, process one bit per cycle, LSB first: diff bit = a^b^borrow; next borrow = (~a&b) | (~(a^b)&borrow).
REQ-017 SHALL shift each diff bit into the MSB of the result register, so that after WIDTH cycles bit 0 sits in the LSB.
REQ-018 SHALL run for exactly WIDTH cycles, counted by a counter of $clog2(WIDTH) bits, moving to DONE after the WIDTH-th bit without wrapping.
REQ-019 SHALL give a latency of WIDTH+1 clocks from the accepting edge to o_valid=1.
REQ-020 SHALL, in DONE, hold o_valid=1 and keep o_diff/o_borrow stable until i_ready=1, then return to IDLE on that edge.
REQ-021 SHALL ignore i_valid while in RUN or DONE; operands offered then are not captured.
REQ-022 SHALL take no new operands on the edge that leaves DONE, so that back-to-back throughput is one result per WIDTH+2 clocks.
REQ-023 SHALL keep o_diff/o_borrow at their last result while in IDLE or RUN; they are qualified only by o_valid.

Reset
REQ-024 SHALL, on i_reset=1, immediately enter IDLE with o_ready=1, o_valid=0, o_diff=0, o_borrow=0, counter=0 and the operand registers at 0.
REQ-025 SHALL, on reset mid-RUN or mid-DONE, abandon the operation with no o_valid pulse; the first edge after deassertion may accept operands.

Configuration
REQ-026 SHALL, with SERIAL_SUB_OVF_EN defined, add port o_overflow (output, 1 bit), set to 1 when the signed two's-complement result overflows (a_msb != b_msb and diff_msb != a_msb); it is held and qualified like o_diff and reset to 0.
REQ-027 SHALL, without SERIAL_SUB_OVF_EN, have no o_overflow port and no related logic.

Structure
REQ-028 SHALL take the FSM state enum (IDLE/RUN/DONE) and the default WIDTH constant from a shared package, sub_pkg.
REQ-029 SHALL instantiate a one-bit combinational sub-module, full_subtractor (inputs i_a, i_b, i_borrow; outputs o_diff, o_borrow), for the per-bit datapath.

Verification (WIDTH=8)
REQ-030 SHALL be checked with: i_a=0x05, i_b=0x03 -> o_valid after 9 clocks with o_diff=0x02 and o_borrow=0.
REQ-031 SHALL be checked with: i_a=0x03, i_b=0x05 -> o_diff=0xFE, o_borrow=1.
REQ-032 SHALL be checked with, macro defined: i_a=0x80, i_b=0x01 -> o_diff=0x7F, o_borrow=0, o_overflow=1; and i_a=0x00, i_b=0x00 -> o_diff=0x00, all flags 0.
REQ-033 SHALL be checked with: i_ready held 0 for 5 cycles in DONE -> o_valid and o_diff stable throughout; i_valid pulses during RUN/DONE are ignored; i_ready=1 -> IDLE on the next edge.
REQ-034 SHALL be checked with: i_reset asserted at RUN bit 4 -> outputs reset immediately with no o_valid; then 0xFF-0x01 -> o_diff=0xFE, o_borrow=0.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit combinational full subtractor: a - b - borrow_in.
module full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_borrow,
    output logic o_diff,
    output logic o_borrow
);

    always_comb begin
        o_diff   = i_a ^ i_b ^ i_borrow;
        o_borrow = (~i_a & i_b) | (~(i_a ^ i_b) & i_borrow);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (LSB first, one bit per clock) with valid/ready handshakes.
// Optional signed-overflow flag o_overflow is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             o_overflow,
`endif
    output logic             o_borrow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic             bit_diff;
    logic             bit_borrow;
    logic             last_bit;

    full_subtractor u_fs (
        .i_a      (a_sr[0]),
        .i_b      (b_sr[0]),
        .i_borrow (borrow),
        .o_diff   (bit_diff),
        .o_borrow (bit_borrow)
    );

    assign last_bit = (state == RUN) && (cnt == LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (i_valid) next_state = RUN;
            RUN:     if (cnt == LAST) next_state = DONE;
            DONE:    if (i_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (state)
            IDLE:    o_ready = 1'b1;
            DONE:    o_valid = 1'b1;
            default: ;
        endcase
    end

    // The minuend register doubles as the result shift register: each consumed
    // minuend bit leaves the LSB while its diff bit enters the MSB.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            a_sr       <= '0;
            b_sr       <= '0;
            borrow     <= 1'b0;
            cnt        <= '0;
            o_diff     <= '0;
            o_borrow   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            o_overflow <= 1'b0;
`endif
        end else if ((state == IDLE) && i_valid) begin
            a_sr   <= i_a;
            b_sr   <= i_b;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sr   <= {bit_diff, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            borrow <= bit_borrow;
            if (!last_bit) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                // Outputs only change here, so they hold the last result in IDLE/RUN.
                o_diff     <= {bit_diff, a_sr[WIDTH-1:1]};
                o_borrow   <= bit_borrow;
`ifdef SERIAL_SUB_OVF_EN
                o_overflow <= (a_sr[0] != b_sr[0]) && (bit_diff != a_sr[0]);
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8); also checks o_overflow when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         i_clk;
    logic         i_reset;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_diff;
    logic         o_borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic         o_overflow;
`endif

    int total = 0;
    int bad   = 0;

    logic [W-1:0] prev_diff;
    logic         prev_borrow;
    logic         prev_ovf;

    serial_subtractor #(.WIDTH(W)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_a        (i_a),
        .i_b        (i_b),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_diff     (o_diff),
`ifdef SERIAL_SUB_OVF_EN
        .o_overflow (o_overflow),
`endif
        .o_borrow   (o_borrow)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands.
    function automatic logic [W-1:0] ref_diff(input int a, input int b);
        return W'((a - b + (1 << W)) % (1 << W));
    endfunction

    function automatic logic ref_ovf(input int a, input int b);
        int sa;
        int sb;
        int r;
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        r  = sa - sb;
        return (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    endfunction

    // Called at a falling edge with the DUT in IDLE; returns at a falling edge back in IDLE.
    task automatic run_op(input int a, input int b, input int hold);
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
        int           edges;
        ed = ref_diff(a, b);
        eb = (a < b);
        eo = ref_ovf(a, b);
        chk("ready_idle", 32'(o_ready), 32'd1);
        i_a     = W'(a);
        i_b     = W'(b);
        i_valid = 1'b1;
        i_ready = 1'b0;
        @(negedge i_clk);
        edges = 1;
        while (!o_valid && edges < 40) begin
            chk("ready_busy", 32'(o_ready), 32'd0);
            chk("diff_held_run", 32'(o_diff), 32'(prev_diff));
            chk("borrow_held_run", 32'(o_borrow), 32'(prev_borrow));
            i_valid = 1'($urandom_range(0, 1));
            i_a     = W'($urandom_range(0, 255));
            i_b     = W'($urandom_range(0, 255));
            @(negedge i_clk);
            edges++;
        end
        chk("latency", 32'(edges), 32'(W + 1));
        for (int k = 0; k <= hold; k++) begin
            chk("valid_done", 32'(o_valid), 32'd1);
            chk("ready_done", 32'(o_ready), 32'd0);
            chk("diff", 32'(o_diff), 32'(ed));
            chk("borrow", 32'(o_borrow), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
            chk("overflow", 32'(o_overflow), 32'(eo));
`endif
            if (k < hold) begin
                i_valid = 1'($urandom_range(0, 1));
                i_a     = W'($urandom_range(0, 255));
                @(negedge i_clk);
            end
        end
        // Leave DONE with operands offered: they must not be taken.
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_a     = W'($urandom_range(0, 255));
        i_b     = W'($urandom_range(0, 255));
        @(negedge i_clk);
        chk("valid_after_ack", 32'(o_valid), 32'd0);
        chk("ready_after_ack", 32'(o_ready), 32'd1);
        chk("diff_held_idle", 32'(o_diff), 32'(ed));
        i_valid     = 1'b0;
        i_ready     = 1'b0;
        prev_diff   = ed;
        prev_borrow = eb;
        prev_ovf    = eo;
        if (eo && 1'b0) prev_ovf = 1'b0;
    endtask

    initial begin
        i_reset     = 1'b1;
        i_valid     = 1'b0;
        i_ready     = 1'b0;
        i_a         = '0;
        i_b         = '0;
        prev_diff   = '0;
        prev_borrow = 1'b0;
        prev_ovf    = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_diff", 32'(o_diff), 32'd0);
        chk("rst_borrow", 32'(o_borrow), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", 32'(o_overflow), 32'd0);
`endif
        i_reset = 1'b0;

        run_op(8'h05, 8'h03, 0);
        run_op(8'h03, 8'h05, 5);
        run_op(8'h80, 8'h01, 1);
        run_op(8'h00, 8'h00, 0);
        run_op(8'hFF, 8'hFF, 0);
        run_op(8'h7F, 8'h80, 2);
        for (int n = 0; n < 20; n++) begin
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 3)));
        end

        // Reset while the bit-serial operation is at bit 4.
        run_op(8'h10, 8'h30, 0);
        i_a     = 8'hAA;
        i_b     = 8'h55;
        i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (4) @(negedge i_clk);
        #2 i_reset = 1'b1;
        #1;
        chk("midrst_ready", 32'(o_ready), 32'd1);
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_diff", 32'(o_diff), 32'd0);
        chk("midrst_borrow", 32'(o_borrow), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("midrst_ovf", 32'(o_overflow), 32'd0);
`endif
        prev_diff   = '0;
        prev_borrow = 1'b0;
        prev_ovf    = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("no_valid_after_rst", 32'(o_valid), 32'd0);
            @(negedge i_clk);
        end
        run_op(8'hFF, 8'h01, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
